// File: rtl/stream_demux4_if.sv
// Handshake bundle between one shared source, the 1:4 demux and its four consumers.
// slave  : the demux view (takes the input stream and the channel ready signals, drives the channels).
// master : the environment view (source plus the four consumers), the mirror image of slave.
interface stream_demux4_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    // Input stream and select
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             addr0;
    logic             addr1;

    // Output channels
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             valid0, valid1, valid2, valid3;
    logic             ready0, ready1, ready2, ready3;

    // Delivered-beat counters and their clear
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
    logic             clr_cnt;

    modport slave (
        input  in_valid, in_data, addr0, addr1,
        input  ready0, ready1, ready2, ready3,
        input  clr_cnt,
        output in_ready,
        output out0, out1, out2, out3,
        output valid0, valid1, valid2, valid3,
        output cnt0, cnt1, cnt2, cnt3
    );

    modport master (
        output in_valid, in_data, addr0, addr1,
        output ready0, ready1, ready2, ready3,
        output clr_cnt,
        input  in_ready,
        input  out0, out1, out2, out3,
        input  valid0, valid1, valid2, valid3,
        input  cnt0, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/stream_demux4.sv
// Routes each accepted input beat to one of four channels chosen by {addr1, addr0}.
// Latency: 1 cycle from accept to valid on the selected channel.
// Backpressure: in_ready = !full[sel] || ready[sel]; a full channel that drains may take a new beat the same cycle.
//
// Ports: clk, reset_n (async active-low) as plain ports; everything else via bus (stream_demux4_if.slave):
//   in_valid/in_ready/in_data, addr0/addr1 select, out0..3/valid0..3/ready0..3 channels,
//   cnt0..3 saturating delivered-beat counters, clr_cnt synchronous counter clear.
module stream_demux4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            reset_n,
    stream_demux4_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       w_sel;
    logic [3:0]       w_out_rdy;
    logic             w_in_rdy;
    logic             w_acc;
    logic [3:0]       w_acc_ch;
    logic [3:0]       w_drain;

    logic [3:0]       r_full;
    logic [WIDTH-1:0] r_hold [4];
    logic [CNT_W-1:0] r_cnt  [4];

    assign w_sel     = {bus.addr1, bus.addr0};
    assign w_out_rdy = {bus.ready3, bus.ready2, bus.ready1, bus.ready0};

    // Ready depends only on the selected channel's state and its consumer, never on in_valid.
    assign w_in_rdy  = !r_full[w_sel] || w_out_rdy[w_sel];
    assign w_acc     = bus.in_valid && w_in_rdy;
    assign w_acc_ch  = w_acc ? (4'b0001 << w_sel) : 4'b0000;
    assign w_drain   = r_full & w_out_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= '0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // An accept wins over a same-cycle drain: the slot is refilled and stays full.
                if (w_acc_ch[i]) begin
                    r_hold[i] <= bus.in_data;
                    r_full[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_full[i] <= 1'b0;
                end

                // Clear has priority, so a beat drained in the clear cycle is not counted.
                if (bus.clr_cnt) begin
                    r_cnt[i] <= '0;
                end else if (w_drain[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready = w_in_rdy;

    assign bus.out0   = r_hold[0];
    assign bus.out1   = r_hold[1];
    assign bus.out2   = r_hold[2];
    assign bus.out3   = r_hold[3];

    assign bus.valid0 = r_full[0];
    assign bus.valid1 = r_full[1];
    assign bus.valid2 = r_full[2];
    assign bus.valid3 = r_full[3];

    assign bus.cnt0   = r_cnt[0];
    assign bus.cnt1   = r_cnt[1];
    assign bus.cnt2   = r_cnt[2];
    assign bus.cnt3   = r_cnt[3];
endmodule

// File: tb/tb_stream_demux4.sv
// Scoreboard bench for stream_demux4: a wide-counter instance and a 2-bit-counter instance share stimulus.
// Driver pushes expected beats per channel on accept; monitor pops/compares on every delivered beat.
// Directed phases follow the plan (routing, back-pressure, isolation, saturation/clear, mid-run reset), then a random soak.
module tb_stream_demux4;
    localparam int W = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    stream_demux4_if #(.WIDTH(W), .CNT_W(8)) bus ();
    stream_demux4_if #(.WIDTH(W), .CNT_W(2)) bus_s ();

    stream_demux4 #(.WIDTH(W), .CNT_W(8)) dut   (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    stream_demux4 #(.WIDTH(W), .CNT_W(2)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bus_s.slave));

    // Stimulus registers, fanned out to both instances
    logic         t_vld = 1'b0;
    logic [1:0]   t_sel = 2'd0;
    logic [W-1:0] t_dat = '0;
    logic [3:0]   t_rdy = 4'h0;
    logic         t_clr = 1'b0;

    assign bus.in_valid = t_vld;    assign bus_s.in_valid = t_vld;
    assign bus.in_data  = t_dat;    assign bus_s.in_data  = t_dat;
    assign bus.addr0    = t_sel[0]; assign bus_s.addr0    = t_sel[0];
    assign bus.addr1    = t_sel[1]; assign bus_s.addr1    = t_sel[1];
    assign bus.ready0   = t_rdy[0]; assign bus_s.ready0   = t_rdy[0];
    assign bus.ready1   = t_rdy[1]; assign bus_s.ready1   = t_rdy[1];
    assign bus.ready2   = t_rdy[2]; assign bus_s.ready2   = t_rdy[2];
    assign bus.ready3   = t_rdy[3]; assign bus_s.ready3   = t_rdy[3];
    assign bus.clr_cnt  = t_clr;    assign bus_s.clr_cnt  = t_clr;

    // Outputs gathered into arrays
    logic [3:0]   o_vld, o_vld_s;
    logic [W-1:0] o_dat [4];
    logic [W-1:0] o_dat_s [4];
    logic [7:0]   o_cnt [4];
    logic [1:0]   o_cnt_s [4];

    assign o_vld   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
    assign o_vld_s = {bus_s.valid3, bus_s.valid2, bus_s.valid1, bus_s.valid0};
    assign o_dat[0] = bus.out0;   assign o_dat[1] = bus.out1;   assign o_dat[2] = bus.out2;   assign o_dat[3] = bus.out3;
    assign o_dat_s[0] = bus_s.out0; assign o_dat_s[1] = bus_s.out1; assign o_dat_s[2] = bus_s.out2; assign o_dat_s[3] = bus_s.out3;
    assign o_cnt[0] = bus.cnt0;   assign o_cnt[1] = bus.cnt1;   assign o_cnt[2] = bus.cnt2;   assign o_cnt[3] = bus.cnt3;
    assign o_cnt_s[0] = bus_s.cnt0; assign o_cnt_s[1] = bus_s.cnt1; assign o_cnt_s[2] = bus_s.cnt2; assign o_cnt_s[3] = bus_s.cnt3;

    // Reference model: one queue per channel (at most one entry outstanding) and per-width counters
    logic [W-1:0] q [4][$];
    int m_cnt [4];
    int m_cnt_s [4];

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Select must be known whenever a beat is offered
    always @(posedge clk) begin
        if (reset_n && t_vld) begin
            assert (!$isunknown(t_sel))
            else begin
                fails++;
                $display("FAIL addr_known: select is %b with in_valid=1", t_sel);
            end
        end
    end

    // Monitor: samples 1 time unit before each rising edge
    always @(negedge clk) begin
        logic exp_rdy;
        logic exp_full;
        #4;
        if (reset_n) begin
            exp_rdy = (q[t_sel].size() == 0) || t_rdy[t_sel];
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            check("in_ready_s", {31'd0, bus_s.in_ready}, {31'd0, exp_rdy});
            for (int i = 0; i < 4; i++) begin
                exp_full = (q[i].size() != 0);
                check($sformatf("valid%0d", i), {31'd0, o_vld[i]}, {31'd0, exp_full});
                check($sformatf("valid%0d_s", i), {31'd0, o_vld_s[i]}, {31'd0, exp_full});
                if (exp_full) begin
                    check($sformatf("out%0d", i), 32'(o_dat[i]), 32'(q[i][0]));
                    check($sformatf("out%0d_s", i), 32'(o_dat_s[i]), 32'(q[i][0]));
                end
                check($sformatf("cnt%0d", i), 32'(o_cnt[i]), m_cnt[i]);
                check($sformatf("cnt%0d_s", i), 32'(o_cnt_s[i]), m_cnt_s[i]);
                if (exp_full && t_rdy[i]) begin
                    void'(q[i].pop_front());
                    if (!t_clr) begin
                        if (m_cnt[i] < 255) m_cnt[i]++;
                        if (m_cnt_s[i] < 3) m_cnt_s[i]++;
                    end
                end
                if (t_clr) begin
                    m_cnt[i] = 0;
                    m_cnt_s[i] = 0;
                end
            end
        end
    end

    // One cycle of stimulus; the expected beat is queued just after the edge that accepts it
    task automatic cyc(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r, input logic c);
        logic acc;
        @(negedge clk);
        t_vld = v;
        t_sel = s;
        t_dat = v ? d : {W{1'bx}};
        t_rdy = r;
        t_clr = c;
        #3;
        acc = v && reset_n && ((q[s].size() == 0) || r[s]);
        #3;
        if (acc) q[s].push_back(d);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        t_vld = 1'b0;
        t_clr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("midrst_valid", {31'd0, o_vld[i]}, 32'd0);
            check("midrst_valid_s", {31'd0, o_vld_s[i]}, 32'd0);
            check("midrst_out", 32'(o_dat[i]), 32'd0);
            check("midrst_cnt", 32'(o_cnt[i]), 32'd0);
            q[i].delete();
            m_cnt[i] = 0;
            m_cnt_s[i] = 0;
        end
        #4 reset_n = 1'b1;
    endtask

    logic [W-1:0] basic_dat [4];
    logic [W-1:0] iso_dat [4];
    int           exp_sat [6];

    initial begin
        basic_dat = '{1'b0, 1'b1, 1'b1, 1'b0};
        iso_dat   = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_sat   = '{0, 1, 2, 3, 3, 3};
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_cnt_s[i] = 0;
        end

        // Reset state
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_valid", {31'd0, o_vld[i]}, 32'd0);
            check("rst_out", 32'(o_dat[i]), 32'd0);
            check("rst_cnt", 32'(o_cnt[i]), 32'd0);
            check("rst_cnt_s", 32'(o_cnt_s[i]), 32'd0);
        end
        #6 reset_n = 1'b1;

        // Basic routing: beat visible on its channel one cycle after accept
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 2'(k), basic_dat[k], 4'hf, 1'b0);
            check("basic_valid", {31'd0, o_vld[k]}, 32'd1);
            check("basic_out", 32'(o_dat[k]), 32'(basic_dat[k]));
        end
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b0);
        for (int i = 0; i < 4; i++) check("basic_cnt", 32'(o_cnt[i]), 32'd1);

        // Back-pressure on channel 2
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b1);
        cyc(1'b1, 2'd2, 1'b1, 4'b1011, 1'b0);
        check("bp_valid2", {31'd0, o_vld[2]}, 32'd1);
        check("bp_out2", 32'(o_dat[2]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 2'd2, 1'b0, 4'b1011, 1'b0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_hold_out2", 32'(o_dat[2]), 32'd1);
        end
        cyc(1'b1, 2'd2, 1'b0, 4'hf, 1'b0);
        check("bp_swap_out2", 32'(o_dat[2]), 32'd0);
        check("bp_swap_valid2", {31'd0, o_vld[2]}, 32'd1);
        check("bp_cnt2_a", 32'(o_cnt[2]), 32'd1);
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b0);
        check("bp_cnt2_b", 32'(o_cnt[2]), 32'd2);
        check("bp_empty2", {31'd0, o_vld[2]}, 32'd0);

        // Isolation: channel 1 stalled while channel 3 streams, X data on idle cycles
        cyc(1'b1, 2'd1, 1'b1, 4'b1101, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 2'd3, iso_dat[k], 4'b1101, 1'b0);
            check("iso_in_ready", {31'd0, bus.in_ready}, 32'd1);
            cyc(1'b0, 2'd0, '0, 4'b1101, 1'b0);
        end
        check("iso_cnt3", 32'(o_cnt[3]), 32'd4);
        check("iso_cnt1", 32'(o_cnt[1]), 32'd0);
        check("iso_valid1", {31'd0, o_vld[1]}, 32'd1);
        check("iso_out1", 32'(o_dat[1]), 32'd1);
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b0);

        // Saturation on the 2-bit instance, then clear against a same-cycle drain
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(k < 5, 2'd0, 1'(k), 4'hf, 1'b0);
            check("sat_cnt0_s", 32'(o_cnt_s[0]), exp_sat[k]);
        end
        cyc(1'b1, 2'd0, 1'b1, 4'hf, 1'b0);
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b1);
        check("clr_cnt0", 32'(o_cnt[0]), 32'd0);
        check("clr_cnt0_s", 32'(o_cnt_s[0]), 32'd0);

        // Reset mid-operation with channels 0 and 2 stalled
        cyc(1'b1, 2'd0, 1'b1, 4'b1010, 1'b0);
        cyc(1'b1, 2'd2, 1'b1, 4'b1010, 1'b0);
        check("pre_rst_valid0", {31'd0, o_vld[0]}, 32'd1);
        check("pre_rst_valid2", {31'd0, o_vld[2]}, 32'd1);
        rst_pulse();
        cyc(1'b1, 2'd0, 1'b1, 4'hf, 1'b0);
        check("post_rst_out0", 32'(o_dat[0]), 32'd1);
        cyc(1'b0, 2'd0, '0, 4'hf, 1'b0);
        check("post_rst_cnt0", 32'(o_cnt[0]), 32'd1);

        // Random soak
        for (int n = 0; n < 10000; n++) begin
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), W'($urandom),
                4'($urandom), $urandom_range(0, 63) == 0);
        end
        for (int k = 0; k < 3; k++) cyc(1'b0, 2'd0, '0, 4'hf, 1'b0);
        for (int i = 0; i < 4; i++) check("soak_drained", q[i].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
